// File: rtl/intr_controller.sv
// Machine-mode interrupt sequencer: synchronises interrupt edges, arbitrates by fixed
// priority, flushes/redirects the pipeline into the trap vector and returns on mret.
module intr_controller #(
    parameter int NUM_SRC     = 4,
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_enable,
    input  logic               global_ie,
    input  logic [XLEN-1:0]    mtvec,
    input  logic [XLEN-1:0]    pc_ex,
    input  logic               pc_ex_valid,
    input  logic               stall,
    input  logic               mret,
    output logic               flush,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    output logic [XLEN-1:0]    epc,
    output logic [XLEN-1:0]    cause,
    output logic               in_handler,
    output logic [NUM_SRC-1:0] pending
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        VECTOR  = 2'd2,
        HANDLER = 2'd3
    } state_t;

    state_t             state_r;
    logic [NUM_SRC-1:0] sync_r [SYNC_STAGES];
    logic [NUM_SRC-1:0] sync_prev_r;
    logic [NUM_SRC-1:0] pending_r;
    logic [XLEN-1:0]    epc_r;
    logic [XLEN-1:0]    cause_r;
    logic               in_handler_r;

    logic [NUM_SRC-1:0] rise_s;
    logic [NUM_SRC-1:0] eligible_s;
    logic [NUM_SRC-1:0] clr_s;
    logic [IDX_W-1:0]   winner_s;
    logic               fire_s;
    logic               ret_s;
    logic               abort_s;
    logic [XLEN-1:0]    base_s;
    logic [XLEN-1:0]    vec_pc_s;
    logic [XLEN-1:0]    redirect_pc_s;

    // Lowest set index wins; scanning downward leaves the lowest index last.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Input synchronisers plus the delayed copy used for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= '0;
            end
            sync_prev_r <= '0;
        end else begin
            sync_r[0] <= irq_src;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
            sync_prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise_s     = sync_r[SYNC_STAGES-1] & ~sync_prev_r;
    assign eligible_s = pending_r & irq_enable;
    assign winner_s   = lowest_set(eligible_s);

    // Trap-entry and return decisions; these act in the same cycle as the pipeline sees them.
    always_comb begin
        fire_s  = 1'b0;
        ret_s   = 1'b0;
        abort_s = 1'b0;
        case (state_r)
            TAKE: begin
                if ((eligible_s == '0) || !global_ie) begin
                    abort_s = 1'b1;
                end else if (!stall && pc_ex_valid) begin
                    fire_s = 1'b1;
                end else begin
                    fire_s = 1'b0;
                end
            end
            HANDLER: begin
                if (mret && !stall) begin
                    ret_s = 1'b1;
                end else begin
                    ret_s = 1'b0;
                end
            end
            default: begin
                fire_s = 1'b0;
            end
        endcase
    end

    // Clear mask for the source being taken this cycle.
    always_comb begin
        clr_s = '0;
        if (fire_s) begin
            clr_s = {{(NUM_SRC-1){1'b0}}, 1'b1} << winner_s;
        end else begin
            clr_s = '0;
        end
    end

    // Trap target; vectored mode offsets by 4 bytes per cause index.
    always_comb begin
        base_s   = {mtvec[XLEN-1:2], 2'b00};
        vec_pc_s = base_s;
        if (mtvec[1:0] == 2'b01) begin
            vec_pc_s = base_s + (XLEN'(cause_r[IDX_W-1:0]) << 2'd2);
        end else begin
            vec_pc_s = base_s;
        end
    end

    // Redirect target mux: mret return takes precedence over the vector cycle.
    always_comb begin
        redirect_pc_s = '0;
        if (ret_s) begin
            redirect_pc_s = epc_r;
        end else if (state_r == VECTOR) begin
            redirect_pc_s = vec_pc_s;
        end else begin
            redirect_pc_s = '0;
        end
    end

    // Pending latch; a new edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= '0;
        end else begin
            pending_r <= (pending_r & ~clr_s) | rise_s;
        end
    end

    // Trap sequencing FSM with saved epc/cause and handler flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            epc_r        <= '0;
            cause_r      <= '0;
            in_handler_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if ((eligible_s != '0) && global_ie) begin
                        state_r <= TAKE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                TAKE: begin
                    if (abort_s) begin
                        state_r <= IDLE;
                    end else if (fire_s) begin
                        epc_r   <= pc_ex;
                        cause_r <= {1'b1, {(XLEN-1-IDX_W){1'b0}}, winner_s};
                        state_r <= VECTOR;
                    end else begin
                        state_r <= TAKE;
                    end
                end
                VECTOR: begin
                    state_r      <= HANDLER;
                    in_handler_r <= 1'b1;
                end
                HANDLER: begin
                    if (ret_s) begin
                        state_r      <= IDLE;
                        in_handler_r <= 1'b0;
                    end else begin
                        state_r <= HANDLER;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    in_handler_r <= 1'b0;
                end
            endcase
        end
    end

    assign flush          = fire_s | ret_s;
    assign redirect_valid = (state_r == VECTOR) | ret_s;
    assign redirect_pc    = redirect_pc_s;
    assign epc            = epc_r;
    assign cause          = cause_r;
    assign in_handler     = in_handler_r;
    assign pending        = pending_r;

endmodule

// File: tb/tb_intr_controller.sv
// Directed bench for intr_controller: trap entry, priority, stall hold, masking, mret and reset.
module tb_intr_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_src;
    logic [3:0]  irq_enable;
    logic        global_ie;
    logic [31:0] mtvec;
    logic [31:0] pc_ex;
    logic        pc_ex_valid;
    logic        stall;
    logic        mret;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic [31:0] cause;
    logic        in_handler;
    logic [3:0]  pending;

    int checks   = 0;
    int failures = 0;

    intr_controller #(.NUM_SRC(4), .XLEN(32), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .irq_src        (irq_src),
        .irq_enable     (irq_enable),
        .global_ie      (global_ie),
        .mtvec          (mtvec),
        .pc_ex          (pc_ex),
        .pc_ex_valid    (pc_ex_valid),
        .stall          (stall),
        .mret           (mret),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .epc            (epc),
        .cause          (cause),
        .in_handler     (in_handler),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Raise the given pins and hold them until the edge has reached pending.
    task automatic pulse(input logic [3:0] m);
        irq_src = m;
        repeat (3) tick();
        irq_src = 4'b0000;
    endtask

    task automatic ret_from_handler();
        mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        irq_src     = 4'b0000;
        irq_enable  = 4'b1111;
        global_ie   = 1'b1;
        mtvec       = 32'h0000_0100;
        pc_ex       = 32'h0000_0040;
        pc_ex_valid = 1'b1;
        stall       = 1'b0;
        mret        = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("rst_flush",   32'(flush), 32'd0);
        chk("rst_rv",      32'(redirect_valid), 32'd0);
        chk("rst_rpc",     redirect_pc, 32'd0);
        chk("rst_epc",     epc, 32'd0);
        chk("rst_cause",   cause, 32'd0);
        chk("rst_inh",     32'(in_handler), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);

        // Direct trap on source 2; pin stays high to show a held level does not retrigger.
        irq_src = 4'b0100;
        tick();
        tick();
        chk("dir_pend_p2", 32'(pending), 32'd0);
        tick();
        chk("dir_pend_p3", 32'(pending), 32'h4);
        chk("dir_noflush_p3", 32'(flush), 32'd0);
        tick();
        chk("dir_flush", 32'(flush), 32'd1);
        chk("dir_rv_take", 32'(redirect_valid), 32'd0);
        tick();
        chk("dir_epc",   epc, 32'h0000_0040);
        chk("dir_cause", cause, 32'h8000_0002);
        chk("dir_rv",    32'(redirect_valid), 32'd1);
        chk("dir_rpc",   redirect_pc, 32'h0000_0100);
        chk("dir_flush_off", 32'(flush), 32'd0);
        chk("dir_pend_clr", 32'(pending), 32'd0);
        tick();
        chk("dir_inh", 32'(in_handler), 32'd1);
        chk("dir_rv_off", 32'(redirect_valid), 32'd0);
        chk("dir_level_norepeat", 32'(pending), 32'd0);

        // mret held off by stall, then a single return cycle.
        mret  = 1'b1;
        stall = 1'b1;
        #1;
        chk("mret_stall_a", 32'(flush), 32'd0);
        tick();
        chk("mret_stall_b", 32'(flush), 32'd0);
        chk("mret_stall_inh", 32'(in_handler), 32'd1);
        tick();
        stall = 1'b0;
        #1;
        chk("mret_flush", 32'(flush), 32'd1);
        chk("mret_rv",    32'(redirect_valid), 32'd1);
        chk("mret_rpc",   redirect_pc, 32'h0000_0040);
        tick();
        mret    = 1'b0;
        irq_src = 4'b0000;
        #1;
        chk("mret_inh_off", 32'(in_handler), 32'd0);
        chk("mret_flush_off", 32'(flush), 32'd0);
        mret = 1'b1;
        #1;
        chk("idle_mret_flush", 32'(flush), 32'd0);
        chk("idle_mret_rv",    32'(redirect_valid), 32'd0);
        tick();
        chk("idle_mret_inh",   32'(in_handler), 32'd0);
        mret = 1'b0;

        // Vectored mode, sources 3 and 1 together: 1 wins, 3 follows after return.
        mtvec = 32'h0000_0201;
        pc_ex = 32'h0000_0080;
        pulse(4'b1010);
        chk("vec_pend_both", 32'(pending), 32'hA);
        tick();
        chk("vec_flush1", 32'(flush), 32'd1);
        tick();
        chk("vec_cause1", cause, 32'h8000_0001);
        chk("vec_rpc1",   redirect_pc, 32'h0000_0204);
        chk("vec_pend_left", 32'(pending), 32'h8);
        tick();
        chk("vec_inh1", 32'(in_handler), 32'd1);
        tick();
        chk("vec_no_nest", 32'(flush), 32'd0);
        mret = 1'b1;
        #1;
        chk("vec_ret_flush", 32'(flush), 32'd1);
        chk("vec_ret_rpc",   redirect_pc, 32'h0000_0080);
        tick();
        mret = 1'b0;
        #1;
        chk("vec_idle_gap_flush", 32'(flush), 32'd0);
        chk("vec_idle_gap_inh",   32'(in_handler), 32'd0);
        tick();
        chk("vec_flush3", 32'(flush), 32'd1);
        tick();
        chk("vec_cause3", cause, 32'h8000_0003);
        chk("vec_rpc3",   redirect_pc, 32'h0000_020C);
        chk("vec_pend_empty", 32'(pending), 32'd0);
        tick();
        ret_from_handler();

        // Stall then bubble hold in TAKE; epc follows the firing cycle's pc_ex.
        mtvec = 32'h0000_0100;
        pc_ex = 32'h0000_1000;
        pulse(4'b0010);
        stall = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            pc_ex = 32'h0000_1000 + 32'(k * 4);
            #1;
            chk("hold_stall", 32'(flush), 32'd0);
            tick();
        end
        stall       = 1'b0;
        pc_ex_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("hold_bubble", 32'(flush), 32'd0);
            tick();
        end
        pc_ex_valid = 1'b1;
        pc_ex       = 32'h0000_2000;
        #1;
        chk("hold_fire", 32'(flush), 32'd1);
        tick();
        stall = 1'b1;
        #1;
        chk("hold_epc",   epc, 32'h0000_2000);
        chk("hold_cause", cause, 32'h8000_0001);
        chk("hold_rv_under_stall", 32'(redirect_valid), 32'd1);
        chk("hold_rpc",   redirect_pc, 32'h0000_0100);
        tick();
        chk("hold_inh", 32'(in_handler), 32'd1);
        stall = 1'b0;
        ret_from_handler();

        // Per-source mask holds source 0 pending until enabled.
        irq_enable = 4'b1110;
        pulse(4'b0001);
        chk("mask_pend", 32'(pending), 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mask_noflush", 32'(flush), 32'd0);
        end
        chk("mask_noinh", 32'(in_handler), 32'd0);
        irq_enable = 4'b1111;
        tick();
        chk("mask_flush", 32'(flush), 32'd1);
        tick();
        chk("mask_cause", cause, 32'h8000_0000);
        tick();
        ret_from_handler();

        // Global enable low blocks everything.
        global_ie = 1'b0;
        pulse(4'b0100);
        repeat (3) tick();
        chk("gie_noflush", 32'(flush), 32'd0);
        chk("gie_noinh",   32'(in_handler), 32'd0);
        chk("gie_pend",    32'(pending), 32'h4);

        // Reset in the middle of a trap discards all state.
        global_ie = 1'b1;
        tick();
        chk("rst2_flush", 32'(flush), 32'd1);
        tick();
        tick();
        chk("rst2_inh_before", 32'(in_handler), 32'd1);
        irq_src = 4'b1000;
        tick();
        reset = 1'b1;
        #1;
        chk("rst2_flush0", 32'(flush), 32'd0);
        chk("rst2_rv0",    32'(redirect_valid), 32'd0);
        chk("rst2_epc0",   epc, 32'd0);
        chk("rst2_cause0", cause, 32'd0);
        chk("rst2_inh0",   32'(in_handler), 32'd0);
        chk("rst2_pend0",  32'(pending), 32'd0);
        irq_src = 4'b0000;
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("rst2_after_inh",  32'(in_handler), 32'd0);
        chk("rst2_after_pend", 32'(pending), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intr_controller.md
Name: intr_controller

Overview:
Machine-mode interrupt sequencer for the three-stage RISC-V pipeline. It synchronises and latches external interrupt edges, and arbitrates between them by fixed priority. It then drives the pipeline flush/redirect into the trap vector and restores the PC on mret. It sits beside the execute stage and CSR file, and feeds the PC-select mux and the stage kill lines.

Parameters:
NUM_SRC, 4, number of interrupt sources; index 0 has the highest priority
XLEN, 32, datapath and PC width
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (minimum 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
irq_src  input  NUM_SRC  raw asynchronous interrupt lines, rising-edge sensitive
irq_enable  input  NUM_SRC  per-source enable mask (mie)
global_ie  input  1  global interrupt enable (mstatus.MIE)
mtvec  input  XLEN  trap base; bits[1:0] 0=direct, 1=vectored, others treated as direct
pc_ex  input  XLEN  PC of the instruction in the execute stage
pc_ex_valid  input  1  execute stage holds a real instruction, not a bubble
stall  input  1  pipeline stalled; no flush or redirect may be issued
mret  input  1  mret is in the execute stage
flush  output  1  kill fetch, decode and execute this cycle
redirect_valid  output  1  next PC = redirect_pc
redirect_pc  output  XLEN  target PC
epc  output  XLEN  saved return PC (mepc)
cause  output  XLEN  mcause value
in_handler  output  1  trap handler active
pending  output  NUM_SRC  latched pending interrupts

Behaviour:
- Reset: all flops clear asynchronously. State=IDLE. flush, redirect_valid, in_handler=0. redirect_pc, epc, cause=0. pending=0. Synchronisers clear.
- Input path: each irq_src bit passes SYNC_STAGES flops, then a rising-edge detector. An edge sets pending[i]. Pin edge to pending visible takes SYNC_STAGES+1 clk. Levels held high cause no repeat.
- Eligible = pending & irq_enable. Winner = lowest set index of eligible.
- FSM states: IDLE, TAKE, VECTOR, HANDLER.
- IDLE:
  - Go to TAKE when eligible!=0 and global_ie=1.
  - mret in IDLE is ignored; no outputs.
- TAKE:
  - Wait while stall=1 or pc_ex_valid=0.
  - On the first cycle with both conditions false:
    - flush=1 for one cycle.
    - epc<=pc_ex.
    - cause<={1'b1, zero-extended winner index}.
    - Clear pending[winner].
    - Go to VECTOR.
  - The winner is re-evaluated every cycle in TAKE.
  - If eligible becomes 0 or global_ie drops before firing, return to IDLE with no outputs.
- VECTOR:
  - redirect_valid=1 for exactly one cycle.
  - redirect_pc = {mtvec[XLEN-1:2],2'b00} when direct.
  - redirect_pc = {mtvec[XLEN-1:2],2'b00} + 4*index when vectored.
  - Next state is HANDLER. VECTOR is not blocked by stall; the PC mux must accept the redirect.
- HANDLER:
  - in_handler=1. No nesting; new edges only set pending.
  - On mret=1 and stall=0: flush=1, redirect_valid=1, redirect_pc=epc, all in the same cycle. Next state IDLE, in_handler=0 next cycle.
- A set and a clear of the same pending bit in the same cycle: set wins (the interrupt stays pending).
- Interrupt taken at most once per edge. Back-to-back interrupts: the next one is taken after returning to IDLE, with at least one IDLE cycle in between.
- Reset asserted mid-trap discards everything, including epc and pending.

Test Plan:
- Reset: assert reset for 1 cycle mid-run -> all outputs 0, state IDLE, pending=0.
- Direct trap:
  - Setup: mtvec=0x0000_0100, irq_enable=4'b1111, global_ie=1, pc_ex=0x0000_0040 valid.
  - Stimulus: pulse irq_src[2].
  - Required response:
    - pending[2] rises 3 clk after the pin edge.
    - flush fires 1 clk later with epc=0x40 and cause=0x8000_0002.
    - Next cycle redirect_pc=0x100.
    - in_handler=1 after that.
- Vectored priority: mtvec=0x0000_0201, pulse irq_src[3] and irq_src[1] together -> cause=0x8000_0001, redirect_pc=0x204, pending=4'b1000 remains. After mret, source 3 is taken with redirect_pc=0x20C.
- Stall/bubble hold: in TAKE, hold stall=1 for 4 cycles then pc_ex_valid=0 for 2 cycles -> no flush until both clear. epc equals pc_ex of the firing cycle.
- Masking:
  - irq_enable[0]=0 and pulse irq_src[0] -> pending[0]=1 and no trap.
  - Then set irq_enable[0]=1 -> trap taken, cause=0x8000_0000.
  - global_ie=0 blocks all sources.
- mret return: in HANDLER with epc=0x40, assert mret while stall=1 for 2 cycles, then stall=0 -> a single cycle with flush=1, redirect_pc=0x40, then in_handler=0. mret in IDLE produces no output.
